// File: rtl/sec_display_pkg.sv
// Shared definitions for the seconds-to-MM:SS display path.
// Covers FSM states, conversion limits and the active-low segment patterns {g,f,e,d,c,b,a}.
package sec_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_BCD  = 2'd2,
        ST_LOAD = 2'd3
    } state_t;

    localparam logic [6:0] DIVISOR = 7'd60;
    localparam logic [6:0] MAX_MIN = 7'd99;
    localparam logic [6:0] MAX_SEC = 7'd59;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_pattern(input logic [3:0] v);
        case (v)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // One double-dabble iteration on {tens, units, 7-bit binary}: add-3 correction, then shift.
    function automatic logic [14:0] dabble_step(input logic [14:0] s);
        logic [14:0] t;
        t = s;
        if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
        if (t[10:7]  >= 4'd5) t[10:7]  = t[10:7]  + 4'd3;
        return {t[13:0], 1'b0};
    endfunction

endpackage

// File: rtl/sec_display_bin_to_mmss.sv
// Sequential binary seconds to BCD minutes/seconds: 16-cycle restoring divide by 60,
// then a 7-cycle double-dabble on both fields. done is high for the single LOAD cycle.
module bin_to_mmss
    import sec_display_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] value,
    output logic        ready,
    output logic        done,
    output logic        busy,
    output logic        ovf_res,
    output logic [3:0]  min_tens,
    output logic [3:0]  min_ones,
    output logic [3:0]  sec_tens,
    output logic [3:0]  sec_ones
);

    state_t      state_q, state_d;
    logic [15:0] work_q, work_d;
    logic [5:0]  rem_q, rem_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [14:0] min_sh_q, min_sh_d;
    logic [14:0] sec_sh_q, sec_sh_d;
    logic        ovf_pend_q, ovf_pend_d;
    logic        busy_q, busy_d;

    logic [6:0]  trial;
    logic        trial_ge;
    logic [5:0]  rem_step;
    logic [15:0] work_step;

    // Remainder stays below 60, so the shifted trial value always fits in 7 bits.
    always_comb begin
        trial     = {rem_q, work_q[15]};
        trial_ge  = (trial >= DIVISOR);
        rem_step  = trial_ge ? 6'(trial - DIVISOR) : trial[5:0];
        work_step = {work_q[14:0], trial_ge};
    end

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        min_sh_d   = min_sh_q;
        sec_sh_d   = sec_sh_q;
        ovf_pend_d = ovf_pend_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d  = value;
                    rem_d   = 6'd0;
                    cnt_d   = 4'd0;
                    state_d = ST_DIV;
                end
            end
            ST_DIV: begin
                work_d = work_step;
                rem_d  = rem_step;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    cnt_d   = 4'd0;
                    state_d = ST_BCD;
                    if (work_step > 16'(MAX_MIN)) begin
                        min_sh_d   = {8'd0, MAX_MIN};
                        sec_sh_d   = {8'd0, MAX_SEC};
                        ovf_pend_d = 1'b1;
                    end else begin
                        min_sh_d   = {8'd0, work_step[6:0]};
                        sec_sh_d   = {9'd0, rem_step};
                        ovf_pend_d = 1'b0;
                    end
                end
            end
            ST_BCD: begin
                min_sh_d = dabble_step(min_sh_q);
                sec_sh_d = dabble_step(sec_sh_q);
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == 4'd6) begin
                    cnt_d   = 4'd0;
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            work_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            min_sh_q   <= '0;
            sec_sh_q   <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            min_sh_q   <= min_sh_d;
            sec_sh_q   <= sec_sh_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
        end
    end

    assign ready    = (state_q == ST_IDLE);
    assign done     = (state_q == ST_LOAD);
    assign busy     = busy_q;
    assign ovf_res  = ovf_pend_q;
    assign min_tens = min_sh_q[14:11];
    assign min_ones = min_sh_q[10:7];
    assign sec_tens = sec_sh_q[14:11];
    assign sec_ones = sec_sh_q[10:7];

endmodule

// File: rtl/sec_display.sv
// MM:SS display driver: detects changes of sec, converts them through bin_to_mmss and
// scans four active-low seven-segment digits, with the colon dot lit on digit 2.
module sec_display
    import sec_display_pkg::*;
#(
    parameter int REFRESH_DIV = 12_500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sec,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        busy,
    output logic        ovf
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [15:0]      sec_last_q, sec_last_d;
    logic             valid_last_q, valid_last_d;
    logic [3:0]       digit_q [4];
    logic [3:0]       digit_d [4];
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       scan_idx_q, scan_idx_d;

    logic       conv_start, conv_ready, conv_done, conv_busy, conv_ovf;
    logic [3:0] conv_min_tens, conv_min_ones, conv_sec_tens, conv_sec_ones;

    assign conv_start = conv_ready && (!valid_last_q || (sec != sec_last_q));

    bin_to_mmss u_conv (
        .clk      (clk),
        .rst      (rst),
        .start    (conv_start),
        .value    (sec),
        .ready    (conv_ready),
        .done     (conv_done),
        .busy     (conv_busy),
        .ovf_res  (conv_ovf),
        .min_tens (conv_min_tens),
        .min_ones (conv_min_ones),
        .sec_tens (conv_sec_tens),
        .sec_ones (conv_sec_ones)
    );

    always_comb begin
        sec_last_d   = sec_last_q;
        valid_last_d = valid_last_q;
        digit_d      = digit_q;
        ovf_d        = ovf_q;
        scan_cnt_d   = scan_cnt_q + CNT_W'(1);
        scan_idx_d   = scan_idx_q;

        if (conv_start) begin
            sec_last_d   = sec;
            valid_last_d = 1'b1;
        end

        // All four digits and ovf change on one edge so no mixed value is ever shown.
        if (conv_done) begin
            digit_d[3] = conv_min_tens;
            digit_d[2] = conv_min_ones;
            digit_d[1] = conv_sec_tens;
            digit_d[0] = conv_sec_ones;
            ovf_d      = conv_ovf;
        end

        if (scan_cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            scan_cnt_d = '0;
            scan_idx_d = scan_idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_last_q   <= '0;
            valid_last_q <= 1'b0;
            digit_q      <= '{default: 4'd0};
            ovf_q        <= 1'b0;
            scan_cnt_q   <= '0;
            scan_idx_q   <= '0;
        end else begin
            sec_last_q   <= sec_last_d;
            valid_last_q <= valid_last_d;
            digit_q      <= digit_d;
            ovf_q        <= ovf_d;
            scan_cnt_q   <= scan_cnt_d;
            scan_idx_q   <= scan_idx_d;
        end
    end

    assign an   = ~(4'b0001 << scan_idx_q);
    assign seg  = seg_pattern(digit_q[scan_idx_q]);
    assign dp   = (scan_idx_q != 2'd2);
    assign busy = conv_busy;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_sec_display.sv
// Bench for sec_display: vector table, random values against an arithmetic MM:SS model,
// and hand-built sequences for scan timing, mid-conversion changes and reset.
module tb_sec_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sec = 16'd0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        busy;
    logic        ovf;

    sec_display #(.REFRESH_DIV(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .sec  (sec),
        .seg  (seg),
        .dp   (dp),
        .an   (an),
        .busy (busy),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [6:0] PAT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef struct {
        logic [15:0] sec;
        logic [15:0] exp_digs;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] seg_to_digit(input logic [6:0] s);
        for (int d = 0; d < 10; d++)
            if (s == PAT[d]) return 4'(d);
        return 4'hF;
    endfunction

    function automatic void model(input int v, output logic [15:0] digs, output logic o);
        int mm, ss;
        if (v >= 6000) begin
            mm = 99; ss = 59; o = 1'b1;
        end else begin
            mm = v / 60; ss = v % 60; o = 1'b0;
        end
        digs = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    // Observe one full frame (16 cycles at REFRESH_DIV=4) and rebuild the four digits.
    task automatic read_display(output logic [15:0] digs, output logic scan_ok, output logic dp_ok);
        int idx;
        logic [3:0] one;
        digs = '1;
        scan_ok = 1'b1;
        dp_ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            idx = -1;
            for (int i = 0; i < 4; i++) begin
                one = 4'b0001 << i;
                if (an == ~one) idx = i;
            end
            if (idx < 0) scan_ok = 1'b0;
            else digs[idx*4 +: 4] = seg_to_digit(seg);
            if ((dp == 1'b0) != (idx == 2)) dp_ok = 1'b0;
        end
    endtask

    task automatic run_conv(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (busy) n++;
            else if (n > 0) break;
        end
    endtask

    task automatic convert_and_check(input logic [15:0] v, input logic [15:0] exp_d,
                                     input logic exp_o, input string tag);
        int n;
        logic [15:0] d;
        logic sok, dok;
        @(negedge clk);
        sec = v;
        run_conv(n);
        check({tag, " busy_cycles"}, n, 24);
        check({tag, " ovf"}, ovf, exp_o);
        read_display(d, sok, dok);
        check({tag, " digits"}, d, exp_d);
        check({tag, " anode_scan"}, sok, 1'b1);
        check({tag, " dp"}, dok, 1'b1);
        $display("conv %s sec=%0d busy_cycles=%0d display=%h ovf=%b", tag, v, n, d, ovf);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c0, prev;
        logic [15:0] d, exp_d;
        logic sok, dok, exp_o, seen, ok, dp_ok2;
        logic [3:0] pa, one;

        vecs[0] = '{16'd75,    16'h0115, 1'b0};
        vecs[1] = '{16'd5999,  16'h9959, 1'b0};
        vecs[2] = '{16'd6000,  16'h9959, 1'b1};
        vecs[3] = '{16'd65535, 16'h9959, 1'b1};
        vecs[4] = '{16'd0,     16'h0000, 1'b0};
        vecs[5] = '{16'd3599,  16'h5959, 1'b0};
        vecs[6] = '{16'd60,    16'h0100, 1'b0};
        vecs[7] = '{16'd119,   16'h0159, 1'b0};

        // Reset state
        rst = 1'b1;
        sec = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset an", an, 4'b1110);
        check("reset seg", seg, 7'b1000000);
        check("reset dp", dp, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset ovf", ovf, 1'b0);
        $display("reset an=%b seg=%b dp=%b busy=%b ovf=%b", an, seg, dp, busy, ovf);
        rst = 1'b0;
        run_conv(n);
        check("first busy_cycles", n, 24);
        read_display(d, sok, dok);
        check("first digits", d, 16'h0000);
        $display("first conversion busy_cycles=%0d display=%h", n, d);

        for (int i = 0; i < 8; i++)
            convert_and_check(vecs[i].sec, vecs[i].exp_digs, vecs[i].exp_ovf, $sformatf("vec%0d", i));

        // Scan order and hold time
        prev = an;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (an == 4'b1110 && 4'(prev) != 4'b1110) begin ok = 1'b1; break; end
            prev = an;
        end
        check("scan sync", ok, 1'b1);
        ok = 1'b1;
        dp_ok2 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            one = 4'b0001 << ((k / 4) % 4);
            pa = ~one;
            if (an != pa) ok = 1'b0;
            if ((dp == 1'b0) != (an == 4'b1011)) dp_ok2 = 1'b0;
        end
        check("scan sequence", ok, 1'b1);
        check("scan dp", dp_ok2, 1'b1);
        $display("scan sequence ok=%b dp_ok=%b", ok, dp_ok2);

        // Random values against the arithmetic model
        prev = 119;
        for (int i = 0; i < 20; i++) begin
            int v;
            v = (i % 4 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 6100));
            if (v == prev) v = (v + 1) % 65536;
            model(v, exp_d, exp_o);
            convert_and_check(16'(v), exp_d, exp_o, $sformatf("rnd%0d", i));
            prev = v;
        end

        // sec changes in the middle of DIV
        convert_and_check(16'd1000, 16'h1640, 1'b0, "pre_mid");
        @(negedge clk);
        sec = 16'd59;
        @(posedge clk); #1;
        c0 = cyc;
        repeat (4) @(posedge clk);
        @(negedge clk);
        sec = 16'd60;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
        check("mid first_done_edge", cyc - c0, 24);
        read_display(d, sok, dok);
        check("mid first digits", d, 16'h0059);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (busy) seen = 1'b1;
            else if (seen) break;
        end
        check("mid final_done_edge", cyc - c0, 49);
        read_display(d, sok, dok);
        check("mid final digits", d, 16'h0100);
        check("mid final ovf", ovf, 1'b0);
        $display("mid-change final display=%h at edge %0d", d, cyc - c0);

        // Reset during BCD
        convert_and_check(16'd6000, 16'h9959, 1'b1, "pre_rst");
        @(negedge clk);
        sec = 16'd125;
        @(posedge clk); #1;
        repeat (18) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst an", an, 4'b1110);
        check("midrst seg", seg, 7'b1000000);
        check("midrst dp", dp, 1'b1);
        check("midrst busy", busy, 1'b0);
        check("midrst ovf", ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        c0 = cyc;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (busy) seen = 1'b1;
            else if (seen) break;
        end
        check("midrst done_edge", cyc - c0, 25);
        read_display(d, sok, dok);
        check("midrst digits", d, 16'h0205);
        check("midrst final ovf", ovf, 1'b0);
        $display("reset-in-BCD display=%h done %0d cycles after release", d, cyc - c0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
